// File: rtl/ex_pkg.sv
// -----------------------------------------------------------------------------
// ex_pkg: shared definitions for the execute stage.
//   - XLEN / MUL_STEP defaults
//   - opcode and R-type funct encodings
//   - execute-stage FSM state encoding
// -----------------------------------------------------------------------------
package ex_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned MUL_STEP_DEF = 1;

    // Primary opcodes, instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes, instruction[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_e;

endpackage

// File: rtl/mul_iter.sv
// -----------------------------------------------------------------------------
// mul_iter: iterative shift-add multiplier, MUL_STEP multiplier bits per cycle.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   start           load a, b and begin XLEN/MUL_STEP steps
//   a, b            operands (unsigned)
//   done_c          high during the final step (combinational)
//   product_c       low XLEN bits of a*b, valid while done_c is high
// -----------------------------------------------------------------------------
module mul_iter
    import ex_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned MUL_STEP = MUL_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done_c,
    output logic [XLEN-1:0] product_c
);

    localparam int unsigned STEPS = XLEN / MUL_STEP;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    logic [XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  partial_c;
    logic [XLEN-1:0]  acc_next_c;

    // Partial product of the low MUL_STEP multiplier bits; the multiplicand
    // is pre-shifted each step so bit weights line up.
    always_comb begin
        partial_c = '0;
        for (int i = 0; i < int'(MUL_STEP); i++) begin
            if (mplier_q[i]) begin
                partial_c = partial_c + (mcand_q << i);
            end
        end
        acc_next_c = acc_q + partial_c;
    end

    // Load on start, otherwise step while the counter is non-zero
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = CNT_W'(STEPS);
        end else if (cnt_q != '0) begin
            acc_d    = acc_next_c;
            mcand_d  = mcand_q << MUL_STEP;
            mplier_d = mplier_q >> MUL_STEP;
            cnt_d    = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Final step: the accumulated sum including this step is the product
    assign done_c    = (cnt_q == CNT_W'(1));
    assign product_c = acc_next_c;

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage: execute stage between register-read and memory stages.
// Decodes instructionRR, computes a 1-cycle ALU / address result or runs an
// iterative MUL, and registers result + instruction for the memory stage.
// Ports:
//   CLOCK, RESETN               clock / async active-low reset
//   in_valid, in_ready          upstream handshake
//   RDR1, RDR2, instructionRR   operands and instruction word
//   out_valid, out_ready        downstream handshake
//   ALUResult                   ALU result or effective address
//   WDEX                        store data (RDR2 at accept)
//   instructionEX               instruction passed through
//   illegal                     undecodable instruction (with out_valid)
//   busy                        multiplier iterating
// -----------------------------------------------------------------------------
module ex_stage
    import ex_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned MUL_STEP = MUL_STEP_DEF
) (
    input  logic            CLOCK,
    input  logic            RESETN,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] RDR1,
    input  logic [XLEN-1:0] RDR2,
    input  logic [XLEN-1:0] instructionRR,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUResult,
    output logic [XLEN-1:0] WDEX,
    output logic [XLEN-1:0] instructionEX,
    output logic            illegal,
    output logic            busy
);

    ex_state_e       state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic            illegal_q, illegal_d;
    logic            busy_q, busy_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] wdex_q, wdex_d;
    logic [XLEN-1:0] instr_q, instr_d;

    logic [5:0]      op_c;
    logic [5:0]      funct_c;
    logic [XLEN-1:0] simm_c;
    logic [XLEN-1:0] zimm_c;
    logic [XLEN-1:0] alu_c;
    logic            illegal_c;
    logic            is_mul_c;
    logic            accept_c;
    logic            mul_start_c;
    logic            mul_done_c;
    logic [XLEN-1:0] mul_product_c;

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept_c = in_valid && in_ready;

    // Decode and single-cycle ALU
    always_comb begin
        op_c      = instructionRR[31:26];
        funct_c   = instructionRR[5:0];
        simm_c    = {{(XLEN - 16){instructionRR[15]}}, instructionRR[15:0]};
        zimm_c    = {{(XLEN - 16){1'b0}}, instructionRR[15:0]};
        alu_c     = '0;
        illegal_c = 1'b0;
        is_mul_c  = 1'b0;
        case (op_c)
            OP_RTYPE: begin
                case (funct_c)
                    FN_ADD:  alu_c = RDR1 + RDR2;
                    FN_SUB:  alu_c = RDR1 - RDR2;
                    FN_AND:  alu_c = RDR1 & RDR2;
                    FN_OR:   alu_c = RDR1 | RDR2;
                    FN_SLT:  alu_c = {{(XLEN - 1){1'b0}}, ($signed(RDR1) < $signed(RDR2))};
                    FN_MUL:  is_mul_c = 1'b1;
                    default: illegal_c = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_c = RDR1 + simm_c;
            OP_ORI:                alu_c = RDR1 | zimm_c;
            default:               illegal_c = 1'b1;
        endcase
    end

    // Next-state and output-register logic
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        illegal_d   = illegal_q;
        busy_d      = busy_q;
        alu_d       = alu_q;
        wdex_d      = wdex_q;
        instr_d     = instr_q;
        mul_start_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    wdex_d  = RDR2;
                    instr_d = instructionRR;
                    if (is_mul_c) begin
                        state_d     = ST_MUL;
                        mul_start_c = 1'b1;
                        busy_d      = 1'b1;
                        illegal_d   = 1'b0;
                    end else begin
                        alu_d       = alu_c;
                        illegal_d   = illegal_c;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // in_ready gating guarantees the previous result has drained
                if (mul_done_c) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    alu_d       = mul_product_c;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
            alu_q       <= '0;
            wdex_q      <= '0;
            instr_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
            alu_q       <= alu_d;
            wdex_q      <= wdex_d;
            instr_q     <= instr_d;
        end
    end

    mul_iter #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk       (CLOCK),
        .rst_n     (RESETN),
        .start     (mul_start_c),
        .a         (RDR1),
        .b         (RDR2),
        .done_c    (mul_done_c),
        .product_c (mul_product_c)
    );

    assign out_valid     = out_valid_q;
    assign illegal       = illegal_q;
    assign busy          = busy_q;
    assign ALUResult     = alu_q;
    assign WDEX          = wdex_q;
    assign instructionEX = instr_q;

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage: directed + randomized bench for ex_stage with a behavioural
// instruction model (plain arithmetic, 64-bit product for MUL).
// -----------------------------------------------------------------------------
module tb_ex_stage;

    logic        CLOCK;
    logic        RESETN;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] RDR1;
    logic [31:0] RDR2;
    logic [31:0] instructionRR;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic [31:0] WDEX;
    logic [31:0] instructionEX;
    logic        illegal;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    localparam int MUL_CYCLES = 32;

    ex_stage dut (
        .CLOCK         (CLOCK),
        .RESETN        (RESETN),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .RDR1          (RDR1),
        .RDR2          (RDR2),
        .instructionRR (instructionRR),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ALUResult     (ALUResult),
        .WDEX          (WDEX),
        .instructionEX (instructionEX),
        .illegal       (illegal),
        .busy          (busy)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] mk_r(input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    // Behavioural reference: what the instruction means
    function automatic void model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic ill, output logic mul);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] se;
        logic [31:0] ze;
        logic [63:0] p;
        op  = ins[31:26];
        fn  = ins[5:0];
        se  = {{16{ins[15]}}, ins[15:0]};
        ze  = {16'h0000, ins[15:0]};
        res = 32'd0;
        ill = 1'b0;
        mul = 1'b0;
        if (op == 6'h00) begin
            case (fn)
                6'h20:   res = a + b;
                6'h22:   res = a - b;
                6'h24:   res = a & b;
                6'h25:   res = a | b;
                6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h18: begin
                    mul = 1'b1;
                    p   = 64'(a) * 64'(b);
                    res = p[31:0];
                end
                default: ill = 1'b1;
            endcase
        end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
            res = a + se;
        end else if (op == 6'h0D) begin
            res = a | ze;
        end else begin
            ill = 1'b1;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present an op and return at #1 after the edge that accepts it
    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        int n;
        in_valid      = 1'b1;
        instructionRR = ins;
        RDR1          = a;
        RDR2          = b;
        n             = 0;
        while (!in_ready && n < 100) begin
            @(posedge CLOCK); #1;
            n++;
        end
        check("accept_wait", 32'(n < 100), 32'd1);
        @(posedge CLOCK); #1;
        in_valid = 1'b0;
    endtask

    // Issue one op, check latency and outputs against the model, optional stall
    task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                          input int stall, input string tag);
        logic [31:0] er;
        logic        ei;
        logic        em;
        int          lat;
        model(ins, a, b, er, ei, em);
        out_ready = (stall == 0);
        send(ins, a, b);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge CLOCK); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), em ? 32'(MUL_CYCLES) : 32'd0);
        check({tag, "_alu"}, ALUResult, er);
        check({tag, "_wdex"}, WDEX, b);
        check({tag, "_instr"}, instructionEX, ins);
        check({tag, "_ill"}, 32'(illegal), 32'(ei));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        if (stall > 0) begin
            repeat (stall) begin
                @(posedge CLOCK); #1;
            end
            check({tag, "_stall"}, {30'd0, out_valid, in_ready}, 32'h2);
            check({tag, "_stall_alu"}, ALUResult, er);
            out_ready = 1'b1;
        end
        @(posedge CLOCK); #1;
        check({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    localparam logic [31:0] I_ADD = 32'h00221820;
    localparam logic [31:0] I_MUL = 32'h00221818;

    initial begin
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        int          kind;

        RESETN        = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b1;
        RDR1          = '0;
        RDR2          = '0;
        instructionRR = '0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_alu", ALUResult, 32'd0);
        check("rst_wdex", WDEX, 32'd0);
        check("rst_instr", instructionEX, 32'd0);
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESETN = 1'b1;
        @(posedge CLOCK); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic ALU / address ops
        run_op(I_ADD, 32'd5, 32'd7, 0, "add");
        check("add_12", ALUResult, 32'd12);
        run_op(mk_r(6'h2A), 32'hFFFF_FFFF, 32'd1, 0, "slt");
        check("slt_1", ALUResult, 32'd1);
        run_op(mk_r(6'h22), 32'hFFFF_FFFF, 32'd1, 0, "sub");
        check("sub_fffffffe", ALUResult, 32'hFFFF_FFFE);
        run_op(mk_i(6'h2B, 16'hFFFC), 32'h100, 32'hDEAD_BEEF, 0, "sw");
        check("sw_fc", ALUResult, 32'h0000_00FC);
        check("sw_wdex", WDEX, 32'hDEAD_BEEF);

        // MUL with a second op waiting on the inputs
        out_ready = 1'b1;
        send(I_MUL, 32'h0001_0001, 32'h0001_0001);
        in_valid      = 1'b1;
        instructionRR = I_ADD;
        RDR1          = 32'd3;
        RDR2          = 32'd4;
        for (int k = 0; k < MUL_CYCLES; k++) begin
            check("mul_busy", {29'd0, busy, in_ready, out_valid}, 32'h4);
            @(posedge CLOCK); #1;
        end
        check("mul_valid", 32'(out_valid), 32'd1);
        check("mul_result", ALUResult, 32'h0002_0001);
        check("mul_wdex", WDEX, 32'h0001_0001);
        check("mul_instr", instructionEX, I_MUL);
        check("mul_idle", {30'd0, busy, in_ready}, 32'h1);
        @(posedge CLOCK); #1;
        in_valid = 1'b0;
        check("mul_next_valid", 32'(out_valid), 32'd1);
        check("mul_next_alu", ALUResult, 32'd7);
        check("mul_next_instr", instructionEX, I_ADD);
        @(posedge CLOCK); #1;
        check("mul_next_drain", 32'(out_valid), 32'd0);

        // Backpressure: hold result 4 cycles, next op accepted on the release edge
        out_ready = 1'b0;
        send(I_ADD, 32'd10, 32'd20);
        in_valid      = 1'b1;
        instructionRR = mk_r(6'h22);
        RDR1          = 32'd50;
        RDR2          = 32'd8;
        for (int k = 0; k < 4; k++) begin
            check("bp_hold", {30'd0, out_valid, in_ready}, 32'h2);
            check("bp_alu", ALUResult, 32'd30);
            check("bp_instr", instructionEX, I_ADD);
            @(posedge CLOCK); #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge CLOCK); #1;
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_alu", ALUResult, 32'd42);
        check("bp_next_instr", instructionEX, mk_r(6'h22));
        @(posedge CLOCK); #1;
        check("bp_drain", 32'(out_valid), 32'd0);

        // Illegal op followed by a legal one
        run_op(32'hFC00_0000, $urandom, $urandom, 0, "ill");
        check("ill_alu0", ALUResult, 32'd0);
        check("ill_flag", 32'(illegal), 32'd1);
        run_op(I_ADD, 32'd100, 32'd23, 0, "post_ill");
        check("post_ill_flag", 32'(illegal), 32'd0);

        // Randomized ops with random stalls
        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 11));
            a    = $urandom;
            b    = $urandom;
            ins  = $urandom;
            case (kind)
                0:  ins = {6'h00, ins[25:6], 6'h20};
                1:  ins = {6'h00, ins[25:6], 6'h22};
                2:  ins = {6'h00, ins[25:6], 6'h24};
                3:  ins = {6'h00, ins[25:6], 6'h25};
                4:  ins = {6'h00, ins[25:6], 6'h2A};
                5:  ins = {6'h08, ins[25:0]};
                6:  ins = {6'h0D, ins[25:0]};
                7:  ins = {6'h23, ins[25:0]};
                8:  ins = {6'h2B, ins[25:0]};
                9:  ins = (n % 3 == 0) ? {6'h00, ins[25:6], 6'h18} : {6'h00, ins[25:6], 6'h20};
                10: ins = {6'h00, ins[25:6], 6'h01};
                default: ins = {6'h3F, ins[25:0]};
            endcase
            run_op(ins, a, b, int'($urandom_range(0, 3)), "rnd");
        end

        // Reset during MUL aborts it
        out_ready = 1'b1;
        send(I_MUL, 32'd1234, 32'd5678);
        repeat (9) begin
            @(posedge CLOCK); #1;
        end
        check("midrst_busy_before", 32'(busy), 32'd1);
        RESETN = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_alu", ALUResult, 32'd0);
        @(negedge CLOCK);
        RESETN = 1'b1;
        repeat (35) begin
            @(posedge CLOCK); #1;
        end
        check("midrst_no_result", {30'd0, out_valid, busy}, 32'd0);
        run_op(I_ADD, 32'd40, 32'd2, 0, "post_rst");
        check("post_rst_42", ALUResult, 32'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
